// File: rtl/shift_issue_stage.sv
// Issue stage ahead of the shift unit: decodes RV32I shifts and queues
// them in an output register backed by a single skid register.
module shift_issue_stage #(
    parameter int CNT_W = 8,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [31:0]      in_rs1,
    input  logic [31:0]      in_rs2,
    input  logic [TAG_W-1:0] in_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [4:0]       out_shamt,
    output logic             out_l_or_r,
    output logic             out_a_or_l,
    output logic [TAG_W-1:0] out_rd,
    output logic             dec_err,
    output logic [CNT_W-1:0] err_cnt
);

    typedef struct packed {
        logic [31:0]      data;
        logic [4:0]       shamt;
        logic             l_or_r;
        logic             a_or_l;
        logic [TAG_W-1:0] rd;
    } entry_t;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_REG = 7'b0110011;
    localparam logic [6:0] F7_LOG = 7'b0000000;
    localparam logic [6:0] F7_ARI = 7'b0100000;

    entry_t           r_out;
    entry_t           r_skid;
    logic             r_out_v;
    logic             r_skid_v;
    logic             r_dec_err;
    logic [CNT_W-1:0] r_err_cnt;

    logic [6:0] w_op;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic       w_imm;
    logic       w_reg;
    logic       w_sll;
    logic       w_srl;
    logic       w_sra;
    logic       w_legal;
    logic       w_acc;
    logic       w_acc_ok;
    logic       w_ill;
    logic       w_out_free;
    entry_t     w_new;
    logic       w_unused;

    assign w_op  = in_inst[6:0];
    assign w_f3  = in_inst[14:12];
    assign w_f7  = in_inst[31:25];
    assign w_imm = (w_op == OP_IMM);
    assign w_reg = (w_op == OP_REG);
    assign w_sll = (w_f3 == 3'b001) && (w_f7 == F7_LOG);
    assign w_srl = (w_f3 == 3'b101) && (w_f7 == F7_LOG);
    assign w_sra = (w_f3 == 3'b101) && (w_f7 == F7_ARI);

    assign w_legal = (w_imm || w_reg) && (w_sll || w_srl || w_sra);

    always_comb begin
        w_new        = '0;
        w_new.data   = in_rs1;
        w_new.shamt  = w_reg ? in_rs2[4:0] : in_inst[24:20];
        w_new.l_or_r = w_sll;
        w_new.a_or_l = w_sra;
        w_new.rd     = in_rd;
    end

    // Anything offered during a flush is discarded, legal or not.
    assign w_acc      = in_valid && !r_skid_v && !flush;
    assign w_acc_ok   = w_acc && w_legal;
    assign w_ill      = w_acc && !w_legal;
    assign w_out_free = !r_out_v || out_ready;

    assign w_unused = ^{in_rs2[31:5], in_inst[19:15], in_inst[11:7]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out     <= '0;
            r_skid    <= '0;
            r_out_v   <= 1'b0;
            r_skid_v  <= 1'b0;
            r_dec_err <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_dec_err <= w_ill;
            if (w_ill && (r_err_cnt != {CNT_W{1'b1}})) begin
                r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
            if (flush) begin
                r_out_v  <= 1'b0;
                r_skid_v <= 1'b0;
            end else if (w_out_free) begin
                if (r_skid_v) begin
                    // Skid drains first so ordering is never inverted.
                    r_out    <= r_skid;
                    r_out_v  <= 1'b1;
                    r_skid_v <= w_acc_ok;
                    if (w_acc_ok) begin
                        r_skid <= w_new;
                    end
                end else begin
                    r_out_v <= w_acc_ok;
                    if (w_acc_ok) begin
                        r_out <= w_new;
                    end
                end
            end else if (w_acc_ok) begin
                r_skid   <= w_new;
                r_skid_v <= 1'b1;
            end
        end
    end

    assign in_ready   = !r_skid_v;
    assign out_valid  = r_out_v;
    assign out_data   = r_out.data;
    assign out_shamt  = r_out.shamt;
    assign out_l_or_r = r_out.l_or_r;
    assign out_a_or_l = r_out.a_or_l;
    assign out_rd     = r_out.rd;
    assign dec_err    = r_dec_err;
    assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_shift_issue_stage.sv
// Directed bench for shift_issue_stage: decode, skid ordering,
// illegal filtering, flush and asynchronous reset.
module tb_shift_issue_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_shamt;
    logic        out_l_or_r;
    logic        out_a_or_l;
    logic [4:0]  out_rd;
    logic        dec_err;
    logic [7:0]  err_cnt;

    int total;
    int bad;

    shift_issue_stage #(.CNT_W(8), .TAG_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_inst    (in_inst),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_rd      (in_rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_shamt  (out_shamt),
        .out_l_or_r (out_l_or_r),
        .out_a_or_l (out_a_or_l),
        .out_rd     (out_rd),
        .dec_err    (dec_err),
        .err_cnt    (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_in(input logic v, input logic [31:0] inst,
                          input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [4:0] rd);
        in_valid = v;
        in_inst  = inst;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_rd    = rd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        set_in(1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
        #2;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b exp=0", out_valid); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%0b exp=1", in_ready); end
        total++;
        if (err_cnt !== 8'd0 || dec_err !== 1'b0) begin bad++; $display("FAIL rst_err cnt=%0d derr=%0b exp 0/0", err_cnt, dec_err); end
        total++;
        if ({out_data, out_shamt, out_l_or_r, out_a_or_l, out_rd} !== 44'd0) begin bad++; $display("FAIL rst_payload data=%h shamt=%0d exp 0", out_data, out_shamt); end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_slli();
        out_ready = 1'b1;
        set_in(1'b1, 32'h00309293, 32'h000000F0, 32'h0, 5'd5);
        step();
        set_in(1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL slli_valid got=%0b exp=1", out_valid); end
        total++;
        if (out_data !== 32'hF0 || out_shamt !== 5'd3) begin bad++; $display("FAIL slli_data data=%h shamt=%0d exp f0/3", out_data, out_shamt); end
        total++;
        if (out_l_or_r !== 1'b1 || out_a_or_l !== 1'b0 || out_rd !== 5'd5) begin bad++; $display("FAIL slli_ctl l=%0b a=%0b rd=%0d exp 1/0/5", out_l_or_r, out_a_or_l, out_rd); end
        step();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL slli_drain got=%0b exp=0", out_valid); end
    endtask

    task automatic test_sra();
        out_ready = 1'b1;
        set_in(1'b1, 32'h4020D233, 32'h80000000, 32'hFFFFFFE4, 5'd4);
        step();
        set_in(1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'h80000000) begin bad++; $display("FAIL sra_data v=%0b data=%h exp 1/80000000", out_valid, out_data); end
        total++;
        if (out_shamt !== 5'd4 || out_l_or_r !== 1'b0 || out_a_or_l !== 1'b1) begin bad++; $display("FAIL sra_ctl shamt=%0d l=%0b a=%0b exp 4/0/1", out_shamt, out_l_or_r, out_a_or_l); end
        step();
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        set_in(1'b1, 32'h0070D313, 32'h11111111, 32'h0, 5'd6);
        step();
        total++;
        if (out_shamt !== 5'd7 || out_l_or_r !== 1'b0 || out_a_or_l !== 1'b0 || out_data !== 32'h11111111) begin
            bad++; $display("FAIL srli shamt=%0d l=%0b a=%0b data=%h exp 7/0/0/11111111", out_shamt, out_l_or_r, out_a_or_l, out_data);
        end
        set_in(1'b1, 32'h002093B3, 32'h22222222, 32'h00000023, 5'd7);
        step();
        total++;
        if (out_shamt !== 5'd3 || out_l_or_r !== 1'b1 || out_a_or_l !== 1'b0 || out_data !== 32'h22222222 || out_rd !== 5'd7) begin
            bad++; $display("FAIL sll shamt=%0d l=%0b a=%0b data=%h rd=%0d exp 3/1/0/22222222/7", out_shamt, out_l_or_r, out_a_or_l, out_data, out_rd);
        end
        set_in(1'b1, 32'h41F0D413, 32'h33333333, 32'h0, 5'd0);
        step();
        total++;
        if (out_shamt !== 5'd31 || out_l_or_r !== 1'b0 || out_a_or_l !== 1'b1 || out_rd !== 5'd0 || out_valid !== 1'b1) begin
            bad++; $display("FAIL srai_rd0 shamt=%0d l=%0b a=%0b rd=%0d v=%0b exp 31/0/1/0/1", out_shamt, out_l_or_r, out_a_or_l, out_rd, out_valid);
        end
        set_in(1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
        step();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        set_in(1'b1, 32'h00309293, 32'hA, 32'h0, 5'd1);
        step();
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'hA || in_ready !== 1'b1) begin bad++; $display("FAIL b2b_a v=%0b data=%h rdy=%0b exp 1/a/1", out_valid, out_data, in_ready); end
        set_in(1'b1, 32'h00309293, 32'hB, 32'h0, 5'd2);
        step();
        total++;
        if (out_data !== 32'hA || in_ready !== 1'b0) begin bad++; $display("FAIL b2b_b data=%h rdy=%0b exp a/0", out_data, in_ready); end
        set_in(1'b1, 32'h00309293, 32'hC, 32'h0, 5'd3);
        step();
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'hA || out_rd !== 5'd1 || in_ready !== 1'b0) begin bad++; $display("FAIL b2b_hold v=%0b data=%h rd=%0d rdy=%0b exp 1/a/1/0", out_valid, out_data, out_rd, in_ready); end
        out_ready = 1'b1;
        step();
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'hB || in_ready !== 1'b1) begin bad++; $display("FAIL b2b_order1 v=%0b data=%h rdy=%0b exp 1/b/1", out_valid, out_data, in_ready); end
        step();
        set_in(1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'hC || out_rd !== 5'd3) begin bad++; $display("FAIL b2b_order2 v=%0b data=%h rd=%0d exp 1/c/3", out_valid, out_data, out_rd); end
        step();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_nodup got=%0b exp=0", out_valid); end
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        set_in(1'b1, 32'h00000013, 32'h5, 32'h0, 5'd1);
        step();
        set_in(1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
        total++;
        if (out_valid !== 1'b0 || dec_err !== 1'b1 || err_cnt !== 8'd1) begin bad++; $display("FAIL ill_addi v=%0b derr=%0b cnt=%0d exp 0/1/1", out_valid, dec_err, err_cnt); end
        step();
        total++;
        if (dec_err !== 1'b0 || err_cnt !== 8'd1) begin bad++; $display("FAIL ill_pulse derr=%0b cnt=%0d exp 0/1", dec_err, err_cnt); end
        set_in(1'b1, 32'h40309293, 32'h5, 32'h0, 5'd1);
        step();
        set_in(1'b1, 32'h0200D313, 32'h5, 32'h0, 5'd1);
        step();
        set_in(1'b1, 32'h002080B3, 32'h5, 32'h0, 5'd1);
        step();
        set_in(1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
        total++;
        if (out_valid !== 1'b0 || dec_err !== 1'b1 || err_cnt !== 8'd4) begin bad++; $display("FAIL ill_malformed v=%0b derr=%0b cnt=%0d exp 0/1/4", out_valid, dec_err, err_cnt); end
        step();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        set_in(1'b1, 32'h00309293, 32'hA, 32'h0, 5'd1);
        step();
        set_in(1'b1, 32'h00309293, 32'hB, 32'h0, 5'd2);
        step();
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin bad++; $display("FAIL flush_full rdy=%0b v=%0b exp 0/1", in_ready, out_valid); end
        flush = 1'b1;
        set_in(1'b1, 32'h00000013, 32'hD, 32'h0, 5'd3);
        step();
        flush = 1'b0;
        set_in(1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL flush_clear v=%0b rdy=%0b exp 0/1", out_valid, in_ready); end
        total++;
        if (dec_err !== 1'b0 || err_cnt !== 8'd4) begin bad++; $display("FAIL flush_err derr=%0b cnt=%0d exp 0/4", dec_err, err_cnt); end
        flush = 1'b1;
        set_in(1'b1, 32'h00309293, 32'hE, 32'h0, 5'd4);
        step();
        flush = 1'b0;
        set_in(1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_legal v=%0b exp 0", out_valid); end
        step();
    endtask

    task automatic test_saturate();
        out_ready = 1'b1;
        set_in(1'b1, 32'h00000013, 32'h0, 32'h0, 5'd0);
        for (int i = 0; i < 300; i++) step();
        set_in(1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
        total++;
        if (err_cnt !== 8'd255 || dec_err !== 1'b1) begin bad++; $display("FAIL sat cnt=%0d derr=%0b exp 255/1", err_cnt, dec_err); end
        step();
        total++;
        if (err_cnt !== 8'd255 || dec_err !== 1'b0) begin bad++; $display("FAIL sat_hold cnt=%0d derr=%0b exp 255/0", err_cnt, dec_err); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        set_in(1'b1, 32'h00309293, 32'hA, 32'h0, 5'd1);
        step();
        set_in(1'b1, 32'h00309293, 32'hB, 32'h0, 5'd2);
        step();
        set_in(1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
        total++;
        if (in_ready !== 1'b0 || err_cnt !== 8'd255) begin bad++; $display("FAIL ares_pre rdy=%0b cnt=%0d exp 0/255", in_ready, err_cnt); end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || err_cnt !== 8'd0 || in_ready !== 1'b1) begin bad++; $display("FAIL ares v=%0b cnt=%0d rdy=%0b exp 0/0/1", out_valid, err_cnt, in_ready); end
        total++;
        if (out_data !== 32'd0 || out_rd !== 5'd0) begin bad++; $display("FAIL ares_payload data=%h rd=%0d exp 0/0", out_data, out_rd); end
        @(negedge clk);
        rst = 1'b0;
        step();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL ares_after v=%0b rdy=%0b exp 0/1", out_valid, in_ready); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_slli();
        test_sra();
        test_stream();
        test_back_to_back();
        test_illegal();
        test_flush();
        test_saturate();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
